// File: rtl/chacha20_stream_decrypt.sv
// chacha20_stream_decrypt: ChaCha20 keystream engine XORed onto a 32-bit ciphertext word stream
module chacha20_stream_decrypt #(
    parameter int ROUNDS = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  counter_init,
    input  logic         ct_valid,
    input  logic [31:0]  ct_data,
    input  logic         ct_last,
    output logic         ct_ready,
    output logic         pt_valid,
    output logic [31:0]  pt_data,
    output logic         pt_last,
    input  logic         pt_ready,
    output logic         busy
);
    localparam int RW = $clog2(ROUNDS);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, STREAM} state_t;

    state_t        state, state_nx;
    logic [31:0]   seed    [16];
    logic [31:0]   init_s  [16];
    logic [31:0]   work    [16];
    logic [31:0]   work_nx [16];
    logic [31:0]   ks      [16];
    logic [RW-1:0] rnd;
    logic [3:0]    idx;
    logic [1:0]    d1, d2, d3;
    logic [127:0]  q;
    logic          accept, round_done, block_done, load;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a_i, b_i, c_i, d_i);
        logic [31:0] a, b, c, d;
        a = a_i + b_i;
        d = rotl(d_i ^ a, 16);
        c = c_i + d;
        b = rotl(b_i ^ c, 12);
        a = a + b;
        d = rotl(d ^ a, 8);
        c = c + d;
        b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    assign ct_ready   = (state == STREAM) & (!pt_valid | pt_ready);
    assign accept     = ct_valid & ct_ready;
    assign busy       = (state != IDLE) | pt_valid;
    assign load       = (state == IDLE) & start & !pt_valid;
    assign round_done = rnd == RW'(ROUNDS - 1);
    assign block_done = accept & (idx == 4'd15) & !ct_last;

    // Initial state image: constants, key words, block counter, nonce words
    always_comb begin
        seed[0] = 32'h61707865;
        seed[1] = 32'h3320646e;
        seed[2] = 32'h79622d32;
        seed[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) seed[4 + i] = key[32*i +: 32];
        seed[12] = counter_init;
        for (int j = 0; j < 3; j++) seed[13 + j] = nonce[32*j +: 32];
    end

    // One half-round: four quarter-rounds; diagonal rounds rotate the b/c/d lanes by 1/2/3
    always_comb begin
        d1 = {1'b0, rnd[0]};
        d2 = {rnd[0], 1'b0};
        d3 = {rnd[0], rnd[0]};
        work_nx = work;
        q = '0;
        for (int k = 0; k < 4; k++) begin
            q = qr(work[{2'd0, 2'(k)}], work[{2'd1, 2'(k) + d1}],
                   work[{2'd2, 2'(k) + d2}], work[{2'd3, 2'(k) + d3}]);
            work_nx[{2'd0, 2'(k)}]      = q[127:96];
            work_nx[{2'd1, 2'(k) + d1}] = q[95:64];
            work_nx[{2'd2, 2'(k) + d2}] = q[63:32];
            work_nx[{2'd3, 2'(k) + d3}] = q[31:0];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   state_nx = load ? ROUND : IDLE;
            ROUND:  state_nx = round_done ? FINAL : ROUND;
            FINAL:  state_nx = STREAM;
            STREAM: state_nx = !accept ? STREAM : ct_last ? IDLE : (idx == 4'd15) ? ROUND : STREAM;
        endcase
    end

    // Keystream datapath: load, iterate half-rounds, feed-forward add, advance counter per block
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                init_s[i] <= '0;
                work[i]   <= '0;
                ks[i]     <= '0;
            end
            rnd <= '0;
            idx <= '0;
        end else begin
            if (load) begin
                for (int i = 0; i < 16; i++) begin
                    init_s[i] <= seed[i];
                    work[i]   <= seed[i];
                end
            end
            if (state == ROUND) begin
                for (int i = 0; i < 16; i++) work[i] <= work_nx[i];
                rnd <= round_done ? '0 : rnd + 1'b1;
            end
            if (state == FINAL) begin
                for (int i = 0; i < 16; i++) ks[i] <= work[i] + init_s[i];
                idx <= '0;
            end
            if (accept) idx <= idx + 1'b1;
            if (block_done) begin
                init_s[12] <= init_s[12] + 32'd1;
                for (int i = 0; i < 16; i++) work[i] <= (i == 12) ? init_s[12] + 32'd1 : init_s[i];
            end
        end
    end

    // Output word register: load on accept, drop when taken with nothing new behind it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pt_valid <= 1'b0;
            pt_data  <= '0;
            pt_last  <= 1'b0;
        end else if (accept) begin
            pt_valid <= 1'b1;
            pt_data  <= ct_data ^ ks[idx];
            pt_last  <= ct_last;
        end else if (pt_ready) begin
            pt_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_chacha20_stream_decrypt.sv
// tb_chacha20_stream_decrypt: scoreboard bench for the ChaCha20 stream decryptor
module tb_chacha20_stream_decrypt;
    localparam int ROUNDS = 20;
    localparam logic [255:0] RFC_KEY =
        256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [95:0] RFC_NONCE = 96'h00000000_4a000000_09000000;

    logic         clk = 1'b0;
    logic         rst, start, ct_valid, ct_last, ct_ready, pt_valid, pt_last, pt_ready, busy;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  counter_init, ct_data, pt_data;

    chacha20_stream_decrypt #(.ROUNDS(ROUNDS)) dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .nonce(nonce),
        .counter_init(counter_init), .ct_valid(ct_valid), .ct_data(ct_data),
        .ct_last(ct_last), .ct_ready(ct_ready), .pt_valid(pt_valid),
        .pt_data(pt_data), .pt_last(pt_last), .pt_ready(pt_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_bad = 0, cyc = 0, acc_cnt = 0, rdy_mode = 0;
    logic [32:0] sb [$];
    logic [31:0] msg_ct [128];
    logic [31:0] msg_pt [128];
    logic        stall_prev = 1'b0;
    logic [32:0] word_prev = '0;
    logic [31:0] rfc_pt [16] = '{
        32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
        32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
        32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
        32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

    // Free-running cycle count for latency measurements
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    // Reference block function: 10 double rounds driven from an index table
    function automatic logic [511:0] chacha_block(input logic [255:0] k, input logic [95:0] n,
                                                  input logic [31:0] c);
        logic [31:0]  s [16];
        logic [31:0]  x [16];
        logic [511:0] out;
        int qi [8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                          '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4 + i] = k[32*i +: 32];
        s[12] = c;
        for (int j = 0; j < 3; j++) s[13 + j] = n[32*j +: 32];
        x = s;
        for (int r = 0; r < 10; r++) begin
            for (int t = 0; t < 8; t++) begin
                int ia = qi[t][0], ib = qi[t][1], ic = qi[t][2], id = qi[t][3];
                x[ia] = x[ia] + x[ib]; x[id] = rl(x[id] ^ x[ia], 16);
                x[ic] = x[ic] + x[id]; x[ib] = rl(x[ib] ^ x[ic], 12);
                x[ia] = x[ia] + x[ib]; x[id] = rl(x[id] ^ x[ia], 8);
                x[ic] = x[ic] + x[id]; x[ib] = rl(x[ib] ^ x[ic], 7);
            end
        end
        for (int i = 0; i < 16; i++) out[32*i +: 32] = x[i] + s[i];
        return out;
    endfunction

    // Random plaintext, encrypted by the model into the ciphertext fed to the DUT
    task automatic prep(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c0, input int len);
        logic [511:0] blk;
        for (int i = 0; i < len; i++) begin
            blk = chacha_block(k, n, c0 + 32'(i / 16));
            msg_pt[i] = $urandom;
            msg_ct[i] = msg_pt[i] ^ blk[32*(i % 16) +: 32];
        end
    endtask

    task automatic send_msg(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c0,
                            input int len, input int gap_pct, input bit use_tab, input bit chk_time);
        int i = 0, low = 0, guard = 0, t0;
        bit seen = 1'b0;
        key = k; nonce = n; counter_init = c0; start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (i < len && guard < 5000) begin
            ct_valid = ($urandom_range(99) >= 32'(gap_pct));
            ct_data  = msg_ct[i];
            ct_last  = (i == len - 1);
            @(negedge clk);
            guard++;
            if (ct_ready && !seen) begin
                seen = 1'b1;
                if (chk_time) check("first_ct_ready_cycle", 64'(cyc - t0), 64'(ROUNDS + 2));
            end
            if (ct_valid && ct_ready) begin
                if (chk_time && i % 16 == 0 && i > 0) check("block_gap", 64'(low), 64'(ROUNDS + 1));
                if (use_tab) sb.push_back({ct_last, rfc_pt[i]});
                else         sb.push_back({ct_last, msg_pt[i]});
                i++;
                acc_cnt++;
                low = 0;
            end else if (!ct_ready) begin
                low++;
            end
            @(posedge clk); #1;
        end
        ct_valid = 1'b0;
        ct_last  = 1'b0;
        check("send_words", 64'(i), 64'(len));
    endtask

    task automatic drain();
        int g = 0;
        while ((sb.size() != 0 || busy) && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("drain_queue", 64'(sb.size()), 64'd0);
        check("drain_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    // Downstream ready: 0 = always, 1 = random, 2 = held low
    initial begin
        pt_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            pt_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(3) != 0) : 1'b0;
        end
    end

    // Monitor: pop and compare each delivered word, check hold behaviour under backpressure
    initial begin
        logic [32:0] exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", 64'(pt_valid), 64'd1);
                    check("hold_word", 64'({pt_last, pt_data}), 64'(word_prev));
                end
                if (pt_valid && !pt_ready) check("bp_ct_ready", 64'(ct_ready), 64'd0);
                if (pt_valid && pt_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL pt_extra: got %h, want no word", pt_data);
                    end else begin
                        exp = sb.pop_front();
                        check("pt_word", 64'({pt_last, pt_data}), 64'(exp));
                    end
                end
                stall_prev = pt_valid && !pt_ready;
                word_prev  = {pt_last, pt_data};
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Directed sequence followed by random round-trip messages
    initial begin
        logic [255:0] rk;
        logic [95:0]  rn;
        logic [31:0]  rc;
        int           len, g;
        rst = 1'b1; start = 1'b0; ct_valid = 1'b0; ct_data = '0; ct_last = 1'b0;
        key = '0; nonce = '0; counter_init = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pt_valid", 64'(pt_valid), 64'd0);
        check("rst_pt_data", 64'(pt_data), 64'd0);
        check("rst_pt_last", 64'(pt_last), 64'd0);
        check("rst_ct_ready", 64'(ct_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) msg_ct[i] = '0;
        send_msg(RFC_KEY, RFC_NONCE, 32'd1, 16, 0, 1'b1, 1'b1);
        drain();

        for (int w = 0; w < 8; w++) rk[32*w +: 32] = $urandom;
        for (int w = 0; w < 3; w++) rn[32*w +: 32] = $urandom;
        prep(rk, rn, 32'h12345678, 16);
        acc_cnt = 0;
        fork
            send_msg(rk, rn, 32'h12345678, 16, 0, 1'b0, 1'b0);
            begin
                g = 0;
                while (acc_cnt < 4 && g < 500) begin
                    @(negedge clk);
                    g++;
                end
                rdy_mode = 2;
                repeat (6) @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain();

        for (int w = 0; w < 8; w++) rk[32*w +: 32] = $urandom;
        for (int w = 0; w < 3; w++) rn[32*w +: 32] = $urandom;
        prep(rk, rn, 32'hFFFFFFFF, 20);
        send_msg(rk, rn, 32'hFFFFFFFF, 20, 0, 1'b0, 1'b1);
        drain();

        for (int w = 0; w < 8; w++) rk[32*w +: 32] = $urandom;
        for (int w = 0; w < 3; w++) rn[32*w +: 32] = $urandom;
        rc = $urandom;
        prep(rk, rn, rc, 5);
        send_msg(rk, rn, rc, 5, 0, 1'b0, 1'b0);
        rdy_mode = 2;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("el_busy_held", 64'(busy), 64'd1);
            check("el_pt_valid_held", 64'(pt_valid), 64'd1);
            start = (j == 0);
        end
        rdy_mode = 0;
        @(negedge clk);
        check("el_busy_until_taken", 64'(busy), 64'd1);
        @(negedge clk);
        check("el_busy_low", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        check("el_start_ignored", 64'({busy, ct_ready}), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) msg_ct[i] = '0;
        send_msg(RFC_KEY, RFC_NONCE, 32'd1, 16, 0, 1'b1, 1'b1);
        drain();

        key = RFC_KEY; nonce = RFC_NONCE; counter_init = 32'd1; start = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("rr_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("rr_pt_valid", 64'(pt_valid), 64'd0);
        check("rr_pt_data", 64'(pt_data), 64'd0);
        check("rr_pt_last", 64'(pt_last), 64'd0);
        check("rr_ct_ready", 64'(ct_ready), 64'd0);
        check("rr_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_msg(RFC_KEY, RFC_NONCE, 32'd1, 16, 0, 1'b1, 1'b1);
        drain();

        rdy_mode = 1;
        for (int m = 0; m < 200; m++) begin
            for (int w = 0; w < 8; w++) rk[32*w +: 32] = $urandom;
            for (int w = 0; w < 3; w++) rn[32*w +: 32] = $urandom;
            rc  = ($urandom_range(3) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(1)) : 32'($urandom);
            len = int'($urandom_range(70, 1));
            prep(rk, rn, rc, len);
            send_msg(rk, rn, rc, len, 20, 1'b0, 1'b0);
            drain();
        end
        rdy_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
